// File: rtl/sram_pkg.sv
// Shared helpers for the parametrised 1R1W SRAM.
// Provides lane merging and the legal read-latency range.
package sram_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;
  localparam int MAX_DW  = 512;

  // Bit i takes new_w when the lane covering it (i / ws) is enabled.
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_DW-1:0] mask,
    input int                ws
  );
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_DW; i++) begin
      if (mask[i / ws]) r[i] = new_w[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_1r1w_param_bypass_rd_pipe.sv
// Read-return pipeline: carries data, valid and collision through
// LATENCY stages. Ports: clk, rst, in_* from the array, registered outputs.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_coll,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  coll
);

  logic [LATENCY-1:0][DATA_WIDTH-1:0] s_data;
  logic [LATENCY-1:0]                 s_valid;
  logic [LATENCY-1:0]                 s_coll;

  // Data registers load only on a valid beat so the output holds
  // the last returned word between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_data  <= '0;
      s_valid <= '0;
      s_coll  <= '0;
    end else begin
      s_valid[0] <= in_valid;
      s_coll[0]  <= in_valid & in_coll;
      if (in_valid) s_data[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        s_valid[i] <= s_valid[i-1];
        s_coll[i]  <= s_coll[i-1];
        if (s_valid[i-1]) s_data[i] <= s_data[i-1];
      end
    end
  end

  assign data  = s_data[LATENCY-1];
  assign valid = s_valid[LATENCY-1];
  assign coll  = s_coll[LATENCY-1];

endmodule

// File: rtl/sram_1r1w_param_bypass.sv
// Single-clock 1R1W SRAM with byte-lane write mask, 1/2-cycle read
// latency, optional read-during-write bypass, valid strobe, collision flag.
// Ports: clk, rst (async high); csb0/addr0/din0/wmask0 write port;
// csb1/addr1 read port; dout1, dout1_valid, collision outputs.
module sram_1r1w_param_bypass
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int WORD_SIZE    = 8,
  parameter int NUM_WMASKS   = DATA_WIDTH / WORD_SIZE,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (WORD_SIZE < 1 || DATA_WIDTH % WORD_SIZE != 0) begin : g_bad_ws
    $fatal(1, "DATA_WIDTH must be a multiple of WORD_SIZE");
  end
  if (NUM_WMASKS * WORD_SIZE != DATA_WIDTH) begin : g_bad_nm
    $fatal(1, "NUM_WMASKS must equal DATA_WIDTH/WORD_SIZE");
  end
  if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_lat
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH > MAX_DW) begin : g_bad_dw
    $fatal(1, "DATA_WIDTH exceeds lane_merge capacity");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_en;
  logic                  rd_en;
  logic                  hit;
  logic [DATA_WIDTH-1:0] old_wr;
  logic [DATA_WIDTH-1:0] old_rd;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [MAX_DW-1:0]     mask_bits;
  logic [MAX_DW-1:0]     merged;

  // Requests seen while rst is high are dropped.
  assign wr_en = ~csb0 & ~rst;
  assign rd_en = ~csb1 & ~rst;
  assign hit   = wr_en & rd_en & (addr0 == addr1);

  assign old_wr = mem[addr0];
  assign old_rd = mem[addr1];

  always_comb begin
    mask_bits = '0;
    mask_bits[NUM_WMASKS-1:0] = wmask0;
    merged = lane_merge(MAX_DW'(old_wr), MAX_DW'(din0),
                        mask_bits, WORD_SIZE);
    wr_word = DATA_WIDTH'(merged);
  end

  // On a same-address hit, wr_word is exactly the per-lane
  // forwarded value: new lanes where masked, old lanes otherwise.
  always_comb begin
    rd_word = old_rd;
    if (BYPASS != 0 && hit) rd_word = wr_word;
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr0] <= wr_word;
  end

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en),
    .in_data  (rd_word),
    .in_coll  (hit),
    .data     (dout1),
    .valid    (dout1_valid),
    .coll     (collision)
  );

endmodule

// File: tb/tb_sram_1r1w_param_bypass.sv
// Bench: four DUT configs (latency 1/2 x bypass 0/1) share one stimulus
// stream and are checked each cycle against a behavioural memory model.
module tb_sram_1r1w_param_bypass;

  logic        clk;
  logic        rst;
  logic        csb0;
  logic [5:0]  addr0;
  logic [31:0] din0;
  logic [3:0]  wmask0;
  logic        csb1;
  logic [5:0]  addr1;

  logic [31:0] dout [4];
  logic        dv   [4];
  logic        col  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sram_1r1w_param_bypass #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (6),
      .WORD_SIZE    (8),
      .READ_LATENCY (g / 2 + 1),
      .BYPASS       (g % 2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .csb0        (csb0),
      .addr0       (addr0),
      .din0        (din0),
      .wmask0      (wmask0),
      .csb1        (csb1),
      .addr1       (addr1),
      .dout1       (dout[g]),
      .dout1_valid (dv[g]),
      .collision   (col[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int cyc;
  int kill;

  logic [31:0] mm [64];
  bit          ev_rd   [16];
  bit          ev_coll [16];
  logic [31:0] ev_d0   [16];
  logic [31:0] ev_d1   [16];
  logic [31:0] last    [4];

  typedef struct {
    int          base;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          coll;
    string       nm;
  } lit_t;
  lit_t lit_q [$];

  // Model: what each read sampled at this edge must return.
  always @(posedge clk) begin : model
    int j;
    logic [31:0] mg;
    cyc++;
    j = cyc % 16;
    ev_rd[j]   = 1'b0;
    ev_coll[j] = 1'b0;
    ev_d0[j]   = '0;
    ev_d1[j]   = '0;
    if (!rst) begin
      if (!csb1) begin
        ev_rd[j] = 1'b1;
        ev_d0[j] = mm[addr1];
        ev_d1[j] = mm[addr1];
      end
      mg = mm[addr0];
      for (int l = 0; l < 4; l++)
        if (wmask0[l]) mg[l*8 +: 8] = din0[l*8 +: 8];
      if (!csb0 && !csb1 && addr0 == addr1) begin
        ev_coll[j] = 1'b1;
        ev_d1[j]   = mg;
      end
      if (!csb0) mm[addr0] = mg;
    end
  end

  // Compare process.
  always @(negedge clk) begin : cmp
    int idx;
    int lat;
    bit ev;
    bit ec;
    if (rst) kill = cyc;
    for (int c = 0; c < 4; c++) begin
      lat = c / 2 + 1;
      idx = cyc - lat + 1;
      ev  = !rst && idx > kill && idx >= 1 && ev_rd[idx % 16];
      ec  = ev && ev_coll[idx % 16];
      if (rst) last[c] = '0;
      else if (ev) last[c] = (c % 2 == 1) ? ev_d1[idx % 16]
                                          : ev_d0[idx % 16];
      n_chk += 3;
      if (dv[c] !== ev) begin
        n_fail++;
        $display("FAIL valid cfg%0d cyc%0d: got %b want %b",
                 c, cyc, dv[c], ev);
      end
      if (dout[c] !== last[c]) begin
        n_fail++;
        $display("FAIL dout cfg%0d cyc%0d: got %h want %h",
                 c, cyc, dout[c], last[c]);
      end
      if (col[c] !== ec) begin
        n_fail++;
        $display("FAIL coll cfg%0d cyc%0d: got %b want %b",
                 c, cyc, col[c], ec);
      end
    end
    foreach (lit_q[k]) begin
      for (int c = 0; c < 4; c++) begin
        logic [31:0] want;
        if (lit_q[k].base + c / 2 == cyc) begin
          want = (c % 2 == 1) ? lit_q[k].d1 : lit_q[k].d0;
          n_chk++;
          if (dv[c] !== 1'b1 || dout[c] !== want ||
              col[c] !== lit_q[k].coll) begin
            n_fail++;
            $display("FAIL %s cfg%0d: got v%b %h c%b want v1 %h c%b",
                     lit_q[k].nm, c, dv[c], dout[c], col[c],
                     want, lit_q[k].coll);
          end
        end
      end
    end
    while (lit_q.size() > 0 && lit_q[0].base + 1 <= cyc)
      void'(lit_q.pop_front());
  end

  task automatic drive(input bit w, input logic [5:0] wa,
                       input logic [31:0] wd, input logic [3:0] wm,
                       input bit r, input logic [5:0] ra,
                       input bit rs);
    @(posedge clk);
    #2;
    csb0   = ~w;
    addr0  = wa;
    din0   = wd;
    wmask0 = wm;
    csb1   = ~r;
    addr1  = ra;
    rst    = rs;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 6'd0, 32'd0, 4'd0, 0, 6'd0, 0);
  endtask

  task automatic expect_lit(input string nm, input logic [31:0] d0,
                            input logic [31:0] d1, input bit c);
    lit_t e;
    e.base = cyc + 1;
    e.d0   = d0;
    e.d1   = d1;
    e.coll = c;
    e.nm   = nm;
    lit_q.push_back(e);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; kill = 0;
    for (int c = 0; c < 4; c++) last[c] = '0;
    rst = 1'b0; csb0 = 1'b1; csb1 = 1'b1;
    addr0 = '0; addr1 = '0; din0 = '0; wmask0 = '0;
    #1 rst = 1'b1;
    repeat (3) drive(0, 6'd0, 32'd0, 4'd0, 0, 6'd0, 1);
    idle(2);

    for (int a = 0; a < 64; a++)
      drive(1, 6'(a), 32'($urandom), 4'hF, 0, 6'd0, 0);

    drive(1, 6'd5, 32'hDEADBEEF, 4'hF, 0, 6'd0, 0);
    drive(0, 6'd0, 32'd0, 4'd0, 1, 6'd5, 0);
    expect_lit("basic", 32'hDEADBEEF, 32'hDEADBEEF, 0);
    idle(2);

    drive(1, 6'd3, 32'h11223344, 4'hF, 0, 6'd0, 0);
    drive(1, 6'd3, 32'hAABBCCDD, 4'b0101, 0, 6'd0, 0);
    drive(0, 6'd0, 32'd0, 4'd0, 1, 6'd3, 0);
    expect_lit("pmask", 32'h11BB33DD, 32'h11BB33DD, 0);
    idle(2);

    drive(1, 6'd7, 32'h0, 4'hF, 0, 6'd0, 0);
    drive(1, 6'd7, 32'hCAFEF00D, 4'b0011, 1, 6'd7, 0);
    expect_lit("coll", 32'h00000000, 32'h0000F00D, 1);
    drive(1, 6'd7, 32'hFFFFFFFF, 4'b0000, 1, 6'd7, 0);
    expect_lit("coll_m0", 32'h0000F00D, 32'h0000F00D, 1);
    idle(2);

    drive(1, 6'd63, 32'h63636363, 4'hF, 0, 6'd0, 0);
    for (int a = 0; a < 64; a++)
      drive(0, 6'd0, 32'd0, 4'd0, 1, 6'(a), 0);
    expect_lit("b2b_last", 32'h63636363, 32'h63636363, 0);
    idle(4);

    drive(1, 6'd20, 32'h5A5A1234, 4'hF, 0, 6'd0, 0);
    drive(0, 6'd0, 32'd0, 4'd0, 1, 6'd20, 0);
    drive(0, 6'd0, 32'd0, 4'd0, 1, 6'd21, 1);
    drive(0, 6'd0, 32'd0, 4'd0, 0, 6'd0, 1);
    idle(2);
    drive(0, 6'd0, 32'd0, 4'd0, 1, 6'd20, 0);
    expect_lit("rst_keep", 32'h5A5A1234, 32'h5A5A1234, 0);
    idle(2);

    drive(1, 6'd9, 32'h0BADF00D, 4'hF, 0, 6'd0, 0);
    drive(0, 6'd0, 32'd0, 4'd0, 1, 6'd9, 0);
    expect_lit("war_old", 32'h0BADF00D, 32'h0BADF00D, 0);
    drive(1, 6'd9, 32'h12345678, 4'hF, 0, 6'd0, 0);
    drive(0, 6'd0, 32'd0, 4'd0, 1, 6'd9, 0);
    expect_lit("war_new", 32'h12345678, 32'h12345678, 0);
    idle(2);

    for (int k = 0; k < 800; k++) begin
      bit w, r, rs;
      w  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 99) == 0);
      drive(w, 6'($urandom_range(0, 7)), 32'($urandom),
            4'($urandom_range(0, 15)), r,
            6'($urandom_range(0, 7)), rs);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_1r1w_param_bypass.md
Name: sram_1r1w_param_bypass

Overview:
- Single-clock, parametrised 1-read/1-write SRAM behavioural model, replacing the fixed 8x16 dual-clock macro model.
- Adds per-byte write mask, selectable 1- or 2-cycle read latency, and read-during-write forwarding.
- Adds a read-valid strobe and a collision flag.
- Sits behind scratchpads and small buffers in the training SoC; synthesisable and X-free on outputs.

Parameters:
- DATA_WIDTH, 32, bits per word; must be a multiple of WORD_SIZE.
- ADDR_WIDTH, 6, address bits; depth = 2**ADDR_WIDTH.
- WORD_SIZE, 8, bits per write-mask lane.
- NUM_WMASKS, DATA_WIDTH/WORD_SIZE, derived, write-mask width.
- READ_LATENCY, 1, cycles from read request to dout1_valid; legal values 1 or 2.
- BYPASS, 1, 1 = same-cycle same-address read returns newly written data; 0 = returns old data.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- csb0  in  1  write enable, active low.
- addr0  in  ADDR_WIDTH  write address.
- din0  in  DATA_WIDTH  write data.
- wmask0  in  NUM_WMASKS  per-lane write enable; bit i covers din0[i*WORD_SIZE +: WORD_SIZE].
- csb1  in  1  read enable, active low.
- addr1  in  ADDR_WIDTH  read address.
- dout1  out  DATA_WIDTH  read data.
- dout1_valid  out  1  one-cycle strobe marking a new dout1.
- collision  out  1  registered flag for a same-cycle same-address read and write.

Behaviour:
- Reset (async, rst=1):
  - dout1=0, dout1_valid=0, collision=0; all pipeline valid bits cleared.
  - Memory array is not cleared; contents persist across reset.
  - A write or read presented on a posedge while rst=1 is ignored.
- Write:
  - Sampled at posedge N when csb0=0.
  - mem[addr0] lanes with wmask0[i]=1 take din0 lanes; other lanes are unchanged.
  - wmask0=0 with csb0=0 is a legal no-op.
- Read, READ_LATENCY=1:
  - Request sampled at posedge N when csb1=0.
  - dout1 and dout1_valid=1 appear after posedge N, i.e. valid during cycle N+1.
- Read, READ_LATENCY=2:
  - Array read at posedge N into an internal stage register.
  - dout1 and dout1_valid appear after posedge N+1.
  - Fully pipelined: one read accepted every cycle, no stalls.
- dout1_valid is high exactly one cycle per accepted read.
- dout1 holds its last value when no read completes; it never goes X or 0 between reads.
- Collision (csb0=0, csb1=0, addr0==addr1 at the same posedge):
  - BYPASS=1: read data per lane = din0 lane if wmask0 lane=1, else old mem lane.
  - BYPASS=0: read data = old mem word.
  - collision=1 for the cycle in which that read's dout1_valid is asserted; 0 otherwise.
  - A collision with wmask0=0 still flags; data = old word.
- Hazards outside the collision case:
  - Write at N+1 to the address read at N does not affect that read (array sampled at N), including when READ_LATENCY=2.
  - Read at N+1 of an address written at N returns the new data.
- Reset mid-operation: in-flight reads are dropped with no dout1_valid; dout1 returns to 0.
- Parameter checks at elaboration: DATA_WIDTH % WORD_SIZE != 0 or READ_LATENCY not in {1,2} -> $fatal.
- No $display traffic in the RTL.

Decomposition:
- Package sram_pkg:
  - Function lane_merge(old, new, mask, WORD_SIZE) used by both the write path and the bypass path.
  - Localparam LAT_MIN=1, LAT_MAX=2.
  - Typedef-free; widths are passed as parameters.
- One sub-module, sram_rd_pipe:
  - Carries data, valid and collision through READ_LATENCY stages, with reset and hold-last-value logic.
  - The top module owns the array, write logic and collision detect.

Test Plan:
- Basic write/read: write addr 5 = 0xDEADBEEF with wmask=4'hF, then read addr 5 -> dout1=0xDEADBEEF with dout1_valid=1 exactly 1 cycle later (LAT=1), or 2 cycles later (LAT=2).
- Partial mask: mem[3]=0x11223344, then write 0xAABBCCDD with wmask=4'b0101, then read 3 -> 0x11BB33DD.
- Collision: mem[7]=0x00000000; same cycle write 7 = 0xCAFEF00D wmask=4'b0011 and read 7 -> BYPASS=1 returns 0x0000F00D with collision=1; BYPASS=0 returns 0x00000000 with collision=1.
- Back-to-back reads at addr 0..63 every cycle with LAT=2 -> 64 consecutive valid strobes, in-order data, no bubbles; dout1 holds the addr 63 value afterwards.
- Reset mid-stream: issue reads at cycles N and N+1 (LAT=2), assert rst at N+1 -> no dout1_valid, dout1=0; after release, read of a word written before reset returns the pre-reset value.
- Write-after-read: read 9 at N, write 9 = 0x12345678 at N+1 (LAT=2) -> dout1 shows old value; a read of 9 at N+2 returns 0x12345678.
